// File: rtl/fft_stream_r2.sv
// Streaming N-point real-input FFT: loads one frame into a bit-reversed register file,
// runs an in-place radix-2 DIT pass at one butterfly per cycle, then unloads X[k] in natural order.
module fft_stream_r2 #(
  parameter int DW    = 32,
  parameter int LOG2N = 3,
  parameter int OW    = DW + LOG2N,
  parameter int TWF   = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic [LOG2N-1:0]     out_idx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int N  = 1 << LOG2N;
  localparam int BW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int PW = OW + 16;

  if (LOG2N < 2 || LOG2N > 4) begin : g_bad_log2n
    $error("fft_stream_r2: LOG2N must be 2..4");
  end
  if (TWF != 14) begin : g_bad_twf
    $error("fft_stream_r2: twiddle table is Q1.14, TWF must be 14");
  end

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t               state_q, state_d;
  logic [LOG2N-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [BW-1:0]        bfly_q, bfly_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_re_q, out_re_d;
  logic signed [OW-1:0] out_im_q, out_im_d;
  logic [LOG2N-1:0]     out_idx_q, out_idx_d;
  logic signed [OW-1:0] re_q [N];
  logic signed [OW-1:0] re_d [N];
  logic signed [OW-1:0] im_q [N];
  logic signed [OW-1:0] im_d [N];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
  endfunction

  // Twiddles indexed on a 16-point circle so one table serves N = 4, 8 and 16.
  function automatic logic signed [15:0] tw_cos(input logic [2:0] k);
    case (k)
      3'd0:    tw_cos = 16'sd16384;
      3'd1:    tw_cos = 16'sd15137;
      3'd2:    tw_cos = 16'sd11585;
      3'd3:    tw_cos = 16'sd6270;
      3'd4:    tw_cos = 16'sd0;
      3'd5:    tw_cos = -16'sd6270;
      3'd6:    tw_cos = -16'sd11585;
      default: tw_cos = -16'sd15137;
    endcase
  endfunction

  function automatic logic signed [15:0] tw_sin(input logic [2:0] k);
    case (k)
      3'd0:    tw_sin = 16'sd0;
      3'd1:    tw_sin = 16'sd6270;
      3'd2:    tw_sin = 16'sd11585;
      3'd3:    tw_sin = 16'sd15137;
      3'd4:    tw_sin = 16'sd16384;
      3'd5:    tw_sin = 16'sd15137;
      3'd6:    tw_sin = 16'sd11585;
      default: tw_sin = 16'sd6270;
    endcase
  endfunction

  function automatic logic signed [OW-1:0] rnd(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] t;
    t   = x + PW'(1 << (TWF - 1));
    rnd = OW'(t >>> TWF);
  endfunction

  logic [LOG2N-1:0]     j_ext, pos, a_idx, b_idx, nxt_idx;
  logic [2:0]           k16;
  logic signed [15:0]   wc, ws;
  logic signed [OW-1:0] ar, ai, br, bi, pr, pi;
  logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;

  // Butterfly addressing and complex multiply b * (c - j s).
  always_comb begin
    j_ext = LOG2N'(bfly_q);
    pos   = j_ext & LOG2N'((1 << stage_q) - 1);
    a_idx = ((j_ext >> stage_q) << (32'(stage_q) + 1)) | pos;
    b_idx = a_idx | LOG2N'(1 << stage_q);
    k16   = 3'(32'(pos) << (3 - 32'(stage_q)));
    wc    = tw_cos(k16);
    ws    = tw_sin(k16);
    ar    = re_q[a_idx];
    ai    = im_q[a_idx];
    br    = re_q[b_idx];
    bi    = im_q[b_idx];
    p_rc  = PW'(br) * PW'(wc);
    p_is  = PW'(bi) * PW'(ws);
    p_ic  = PW'(bi) * PW'(wc);
    p_rs  = PW'(br) * PW'(ws);
    pr    = rnd(p_rc) + rnd(p_is);
    pi    = rnd(p_ic) - rnd(p_rs);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    bfly_d      = bfly_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    re_d        = re_q;
    im_d        = im_q;
    frame_done  = 1'b0;
    nxt_idx     = out_idx_q + 1'b1;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          re_d[bitrev(cnt_q)] = OW'(in_data);
          im_d[bitrev(cnt_q)] = '0;
          if (cnt_q == LOG2N'(N - 1)) begin
            cnt_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        re_d[a_idx] = ar + pr;
        im_d[a_idx] = ai + pi;
        re_d[b_idx] = ar - pr;
        im_d[b_idx] = ai - pi;
        if (bfly_q == '1) begin
          bfly_d = '0;
          if (stage_q == SW'(LOG2N - 1)) begin
            stage_d = '0;
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          bfly_d = bfly_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        // Output register is empty on entry; fill it with bin 0, then advance per accepted beat.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_re_d    = re_q[0];
          out_im_d    = im_q[0];
        end else if (out_ready) begin
          if (out_idx_q == '1) begin
            out_valid_d = 1'b0;
            frame_done  = 1'b1;
            state_d     = S_LOAD;
          end else begin
            out_idx_d = nxt_idx;
            out_re_d  = re_q[nxt_idx];
            out_im_d  = im_q[nxt_idx];
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_fft_stream_r2.sv
// Directed-vector bench for fft_stream_r2: an N=8 instance driven from a vector table,
// plus backpressure, mid-frame reset and an N=16 instance.
module tb_fft_stream_r2;

  localparam int DW   = 32;
  localparam int OW8  = DW + 3;
  localparam int OW16 = DW + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                  in_valid8, in_ready8, out_valid8, out_ready8, busy8, done8;
  logic signed [DW-1:0]  in_data8;
  logic signed [OW8-1:0] out_re8, out_im8;
  logic [2:0]            out_idx8;

  logic                   in_valid16, in_ready16, out_valid16, out_ready16, busy16, done16;
  logic signed [DW-1:0]   in_data16;
  logic signed [OW16-1:0] out_re16, out_im16;
  logic [3:0]             out_idx16;

  fft_stream_r2 #(.DW(DW), .LOG2N(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_re(out_re8), .out_im(out_im8),
    .out_idx(out_idx8), .busy(busy8), .frame_done(done8));

  fft_stream_r2 #(.DW(DW), .LOG2N(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_re(out_re16), .out_im(out_im16),
    .out_idx(out_idx16), .busy(busy16), .frame_done(done16));

  typedef struct packed {
    logic [7:0][31:0] x;
    logic [7:0][39:0] er;
    logic [7:0][39:0] ei;
    logic [7:0]       tol;
  } vec_t;

  vec_t vecs [5];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    total++;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic send8(input vec_t v);
    int g;
    for (int i = 0; i < 8; i++) begin
      in_valid8 = 1'b1;
      in_data8  = $signed(v.x[i]);
      g = 0;
      while (!in_ready8 && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      if (!in_ready8) chk("in_ready8 timeout", 0, 1, 0);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
  endtask

  // Counts edges after the last input beat; junk is offered meanwhile and must be ignored.
  task automatic lat8(output int n);
    n = 0;
    in_valid8 = 1'b1;
    in_data8  = 32'sd12345;
    while (!out_valid8 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) chk("busy8 in compute", longint'(busy8), 1, 0);
    end
    in_valid8 = 1'b0;
  endtask

  task automatic recv8(input vec_t v, input int tag, input int hold_k);
    int g;
    longint sre, sim, sidx;
    for (int k = 0; k < 8; k++) begin
      out_ready8 = 1'b1;
      g = 0;
      while (!out_valid8 && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
      if (!out_valid8) begin
        chk($sformatf("v%0d out_valid8 timeout k=%0d", tag, k), 0, 1, 0);
        out_ready8 = 1'b0;
        return;
      end
      chk($sformatf("v%0d idx k=%0d", tag, k), longint'(out_idx8), k, 0);
      chk($sformatf("v%0d re k=%0d", tag, k), longint'(out_re8), longint'($signed(v.er[k])), longint'(v.tol));
      chk($sformatf("v%0d im k=%0d", tag, k), longint'(out_im8), longint'($signed(v.ei[k])), longint'(v.tol));
      chk($sformatf("v%0d in_ready8 low k=%0d", tag, k), longint'(in_ready8), 0, 0);
      if (k == hold_k) begin
        out_ready8 = 1'b0;
        sre = longint'(out_re8); sim = longint'(out_im8); sidx = longint'(out_idx8);
        repeat (5) begin
          @(posedge clk); #1;
          chk("hold re", longint'(out_re8), sre, 0);
          chk("hold im", longint'(out_im8), sim, 0);
          chk("hold idx", longint'(out_idx8), sidx, 0);
          chk("hold valid", longint'(out_valid8), 1, 0);
          chk("hold done", longint'(done8), 0, 0);
        end
        out_ready8 = 1'b1;
      end
      chk($sformatf("v%0d frame_done k=%0d", tag, k), longint'(done8), (k == 7) ? 1 : 0, 0);
      @(posedge clk); #1;
    end
    out_ready8 = 1'b0;
    chk($sformatf("v%0d out_valid8 after", tag), longint'(out_valid8), 0, 0);
    chk($sformatf("v%0d in_ready8 after", tag), longint'(in_ready8), 1, 0);
    chk($sformatf("v%0d busy8 after", tag), longint'(busy8), 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cosx [8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    int n, g;

    rst_n = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      vecs[0].x[i] = 32'd1;
      vecs[0].er[i] = (i == 0) ? 40'd8 : 40'd0;
      vecs[1].x[i] = (i == 0) ? 32'd5 : 32'd0;
      vecs[1].er[i] = 40'd5;
      vecs[2].x[i] = (i % 2 == 0) ? 32'd1 : 32'(-1);
      vecs[2].er[i] = (i == 4) ? 40'd8 : 40'd0;
      vecs[3].x[i] = 32'(cosx[i]);
      vecs[3].er[i] = (i == 1 || i == 7) ? 40'd4000 : 40'd0;
      vecs[4].x[i] = 32'h8000_0000;
      vecs[4].er[i] = (i == 0) ? 40'(-64'sd17179869184) : 40'd0;
      for (int v = 0; v < 5; v++) vecs[v].ei[i] = 40'd0;
    end
    vecs[0].tol = 8'd0; vecs[1].tol = 8'd0; vecs[2].tol = 8'd0;
    vecs[3].tol = 8'd1; vecs[4].tol = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", longint'(in_ready8), 1, 0);
    chk("reset out_valid", longint'(out_valid8), 0, 0);
    chk("reset busy", longint'(busy8), 0, 0);
    chk("reset frame_done", longint'(done8), 0, 0);
    chk("reset out_re", longint'(out_re8), 0, 0);
    chk("reset out_im", longint'(out_im8), 0, 0);
    chk("reset out_idx", longint'(out_idx8), 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      send8(vecs[v]);
      lat8(n);
      chk($sformatf("v%0d latency", v), n, 13, 0);
      recv8(vecs[v], v, -1);
    end

    // Backpressure at bin 3.
    send8(vecs[2]);
    lat8(n);
    recv8(vecs[2], 10, 3);

    // Reset in the middle of COMPUTE, then a clean frame.
    send8(vecs[1]);
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset busy", longint'(busy8), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid reset in_ready", longint'(in_ready8), 1, 0);
    chk("mid reset out_valid", longint'(out_valid8), 0, 0);
    chk("mid reset busy", longint'(busy8), 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    g = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid8) g++;
    end
    chk("no output after reset", g, 0, 0);
    send8(vecs[0]);
    lat8(n);
    chk("post-reset latency", n, 13, 0);
    recv8(vecs[0], 20, -1);

    // N = 16 all-ones frame.
    for (int i = 0; i < 16; i++) begin
      in_valid16 = 1'b1;
      in_data16  = 32'sd1;
      g = 0;
      while (!in_ready16 && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("n16 latency", n, 33, 0);
    out_ready16 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      g = 0;
      while (!out_valid16 && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
      chk($sformatf("n16 idx k=%0d", k), longint'(out_idx16), k, 0);
      chk($sformatf("n16 re k=%0d", k), longint'(out_re16), (k == 0) ? 16 : 0, 0);
      chk($sformatf("n16 im k=%0d", k), longint'(out_im16), 0, 0);
      chk($sformatf("n16 frame_done k=%0d", k), longint'(done16), (k == 15) ? 1 : 0, 0);
      @(posedge clk); #1;
    end
    out_ready16 = 1'b0;
    chk("n16 in_ready after", longint'(in_ready16), 1, 0);
    chk("n16 out_valid after", longint'(out_valid16), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
